// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one 4096x16 memory read port between NUM_REQ requesters.
// Optional WAIT timeout enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [12*NUM_REQ-1:0]   req_addr,
  output logic [NUM_REQ-1:0]      done,
  output logic [15:0]             rdata,
  output logic                    err,
  output logic                    busy,
  output logic                    mem_req,
  output logic [11:0]             mem_addr,
  input  logic                    mem_ready,
  input  logic [15:0]             mem_data
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

  state_t               state_q, state_d;
  logic [1:0]           last_q, last_d;
  logic [1:0]           idx_q, idx_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [15:0]          rdata_q, rdata_d;
  logic                 busy_q, busy_d;
  logic                 mem_req_q, mem_req_d;
  logic [11:0]          mem_addr_q, mem_addr_d;

  logic [3:0]           req_pad;
  logic [47:0]          addr_pad;
  logic                 grant_found;
  logic [1:0]           grant_idx;
  logic [11:0]          grant_addr;
  logic [3:0]           done_onehot;
  logic                 timeout_hit;

  // Pad to the 4-requester maximum so selection logic is width-independent.
  assign req_pad  = 4'(req_valid);
  assign addr_pad = 48'(req_addr);

  always_comb begin : arbitrate
    int cand;
    cand        = 0;
    grant_found = 1'b0;
    grant_idx   = 2'd0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last_q) + k) % NUM_REQ;
      if (!grant_found && req_pad[2'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = 2'(cand);
      end
    end
  end

  always_comb begin
    case (grant_idx)
      2'd0:    grant_addr = addr_pad[11:0];
      2'd1:    grant_addr = addr_pad[23:12];
      2'd2:    grant_addr = addr_pad[35:24];
      default: grant_addr = addr_pad[47:36];
    endcase
  end

`ifdef MEM_ARB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;

  // Limit is hit on the WAIT cycle that would bring the count to TIMEOUT_CYCLES.
  assign timeout_hit = (state_q == WAIT) && !mem_ready && (cnt_q == 8'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ISSUE)
      cnt_d = 8'd0;
    else if ((state_q == WAIT) && !mem_ready)
      cnt_d = cnt_q + 8'd1;
    err_d = timeout_hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_q     <= 2'(NUM_REQ - 1);
      idx_q      <= 2'd0;
      done_q     <= '0;
      rdata_q    <= 16'h0000;
      busy_q     <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= 12'h000;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      idx_q      <= idx_d;
      done_q     <= done_d;
      rdata_q    <= rdata_d;
      busy_q     <= busy_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_found) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (mem_ready || timeout_hit) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    last_d     = last_q;
    idx_d      = idx_q;
    mem_addr_d = mem_addr_q;
    rdata_d    = rdata_q;
    if ((state_q == IDLE) && grant_found) begin
      last_d     = grant_idx;
      idx_d      = grant_idx;
      mem_addr_d = grant_addr;
    end
    if ((state_q == WAIT) && mem_ready)
      rdata_d = mem_data;
    else if (timeout_hit)
      rdata_d = 16'h0000;
    done_onehot = 4'b0001 << idx_q;
    done_d      = (state_d == DONE) ? done_onehot[NUM_REQ-1:0] : '0;
    busy_d      = (state_d != IDLE);
    mem_req_d   = (state_d == ISSUE);
  end

  assign done     = done_q;
  assign rdata    = rdata_q;
  assign busy     = busy_q;
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized phase, checked against a
// transaction-level reference model of the arbitration and memory handshake rules.
module tb_mem_arbiter;
  localparam int N   = 2;
  localparam int IW  = $clog2(N);
  localparam int AW  = 12 * N;
  localparam int TMO = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [AW-1:0]  req_addr;
  logic [N-1:0]   done;
  logic [15:0]    rdata;
  logic           err;
  logic           busy;
  logic           mem_req;
  logic [11:0]    mem_addr;
  logic           mem_ready;
  logic [15:0]    mem_data;

  mem_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .done(done), .rdata(rdata), .err(err), .busy(busy), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc_n = 0;

  // memory responder
  logic [15:0] mem [4096];
  int          lat;
  bit          lat_rand;
  int          rem;
  logic [11:0] r_addr;
  bit          stray;
  bit          rnd_req;

  // reference model
  bit          act;
  int          m_last, exp_idx, exp_req_cyc, exp_done_cyc, wait_from;
  logic [11:0] exp_addr, m_addr;
  logic [15:0] exp_data, m_rdata;
  bit          exp_err;
  logic [N-1:0]  p_req;
  logic [AW-1:0] p_addr;
  logic          p_ready, p_rst;
  logic [15:0]   p_data;
  int            grants[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cyc_n);
    end
  endtask

  function automatic int rr(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (last + k) % N;
      if (r[IW'(c)]) return c;
    end
    return -1;
  endfunction

  function automatic logic [AW-1:0] set_addr(input logic [AW-1:0] v, input int i, input logic [11:0] a);
    logic [AW-1:0] m;
    m = AW'(12'hFFF) << (12 * i);
    return (v & ~m) | (AW'(a) << (12 * i));
  endfunction

  task automatic model_reset();
    act = 1'b0; m_last = N - 1; m_rdata = 16'h0; m_addr = 12'h0;
    exp_req_cyc = -1; exp_done_cyc = -1; exp_err = 1'b0;
  endtask

  task automatic cyc();
    logic [N-1:0] ed;
    logic [IW-1:0] ii;
    bit done_now;
    p_req = req_valid; p_addr = req_addr; p_ready = mem_ready; p_data = mem_data; p_rst = rst_n;
    @(posedge clk); #1;
    cyc_n++;
    // advance the model by the cycle whose inputs were just sampled
    if (!p_rst) model_reset();
    else if (!act) begin
      if (p_req != '0) begin
        exp_idx = rr(p_req, m_last); m_last = exp_idx; act = 1'b1;
        exp_addr = 12'(p_addr >> (12 * exp_idx)); m_addr = exp_addr;
        exp_req_cyc = cyc_n; wait_from = cyc_n + 1; exp_done_cyc = -1;
      end
    end else if (exp_done_cyc >= 0) begin
      if (exp_done_cyc < cyc_n) act = 1'b0;
    end else if (cyc_n - 1 >= wait_from) begin
      if (p_ready) begin
        exp_done_cyc = cyc_n; exp_data = p_data; exp_err = 1'b0;
      end
`ifdef MEM_ARB_TIMEOUT_EN
      else if (cyc_n - wait_from == TMO) begin
        exp_done_cyc = cyc_n; exp_data = 16'h0; exp_err = 1'b1;
      end
`endif
    end
    done_now = act && (exp_done_cyc == cyc_n);
    if (done_now) m_rdata = exp_data;
    ed = done_now ? N'(32'd1 << exp_idx) : '0;
    chk("mem_req", 32'(mem_req), 32'(act && (exp_req_cyc == cyc_n)));
    chk("busy", 32'(busy), 32'(act));
    chk("done", 32'(done), 32'(ed));
    chk("rdata", 32'(rdata), 32'(m_rdata));
    chk("err", 32'(err), 32'(done_now && exp_err));
    chk("mem_addr", 32'(mem_addr), 32'(m_addr));
    for (int i = 0; i < N; i++) begin
      ii = IW'(i);
      if (done[ii]) grants.push_back(i);
    end
    // memory responder drive for this cycle
    mem_ready = 1'b0;
    mem_data  = 16'($urandom);
    if (rem > 0) begin
      rem--;
      if (rem == 0) begin mem_ready = 1'b1; mem_data = mem[r_addr]; end
    end
    if (mem_req && (lat > 0 || lat_rand)) begin
      rem = lat_rand ? int'($urandom_range(1, 5)) : lat;
      r_addr = mem_addr;
    end
    if (stray && !mem_ready && (!busy || mem_req))
      mem_ready = lat_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    // random requesters: hold while being served, may drop while still waiting for a grant
    if (rnd_req) begin
      for (int i = 0; i < N; i++) begin
        ii = IW'(i);
        if (done[ii]) begin
          if ($urandom_range(0, 1) == 0) req_valid[ii] = 1'b0;
          else req_addr = set_addr(req_addr, i, 12'($urandom));
        end else if (!req_valid[ii]) begin
          if ($urandom_range(0, 2) == 0) begin
            req_valid[ii] = 1'b1;
            req_addr = set_addr(req_addr, i, 12'($urandom));
          end
        end else if (!(act && exp_idx == i) && $urandom_range(0, 15) == 0) begin
          req_valid[ii] = 1'b0;
        end
      end
    end
  endtask

  task automatic wait_done(input int maxc, output int at);
    at = -1;
    for (int k = 0; k < maxc; k++) begin
      cyc();
      if (done != '0) begin at = cyc_n; break; end
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && busy; k++) cyc();
    chk("drain_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    int t0, at, i0;
    bit saw_done;
    for (int i = 0; i < 4096; i++) mem[12'(i)] = 16'($urandom);
    mem[12'h001] = 16'h002A;
    rst_n = 1'b0; req_valid = '0; req_addr = '0; mem_ready = 1'b0; mem_data = 16'h0;
    lat = 1; lat_rand = 1'b0; rem = 0; r_addr = 12'h0; stray = 1'b0; rnd_req = 1'b0;
    model_reset();
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();

    // single read, memory answers one cycle after the strobe
    req_valid = 2'b01; req_addr = set_addr(req_addr, 0, 12'h001);
    t0 = cyc_n;
    wait_done(10, at);
    chk("t1_latency", 32'(at - t0), 32'd3);
    chk("t1_done", 32'(done), 32'h1);
    chk("t1_rdata", 32'(rdata), 32'h002A);
    req_valid = '0;
    cyc(); cyc();

    // contention from reset release
    rst_n = 1'b0; cyc(); cyc();
    req_addr = set_addr(req_addr, 0, 12'($urandom));
    req_addr = set_addr(req_addr, 1, 12'($urandom));
    req_valid = 2'b11; rst_n = 1'b1;
    grants.delete();
    for (int k = 0; k < 40 && grants.size() < 4; k++) cyc();
    chk("cont_count", 32'(grants.size()), 32'd4);
    for (int k = 0; k < grants.size() && k < 4; k++) chk("cont_order", 32'(grants[k]), 32'(k % 2));
    req_valid = '0;
    drain();

    // slow memory with stray ready pulses in IDLE and ISSUE
    lat = 10; stray = 1'b1;
    cyc(); cyc();
    req_valid = 2'b10; req_addr = set_addr(req_addr, 1, 12'($urandom));
    t0 = cyc_n;
    wait_done(30, at);
    chk("slow_latency", 32'(at - t0), 32'd12);
    chk("slow_done", 32'(done), 32'h2);
    req_valid = '0; stray = 1'b0;
    cyc(); cyc();

    // reset during WAIT, late ready arrives while idle
    lat = 6;
    req_valid = 2'b01; req_addr = set_addr(req_addr, 0, 12'($urandom));
    for (int k = 0; k < 10 && !mem_req; k++) cyc();
    chk("rst_issue", 32'(mem_req), 32'd1);
    cyc(); cyc();
    rst_n = 1'b0; req_valid = '0;
    cyc(); cyc();
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int k = 0; k < 5; k++) begin cyc(); if (done != '0) saw_done = 1'b1; end
    chk("rst_no_done", 32'(saw_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    lat = 1;
    req_valid = 2'b11;
    wait_done(10, at);
    chk("rst_first_grant", 32'(done), 32'h1);
    req_valid = '0;
    drain();

    // memory that never answers
    lat = 0;
    req_valid = 2'b01; req_addr = set_addr(req_addr, 0, 12'($urandom));
    for (int k = 0; k < 10 && !mem_req; k++) cyc();
    i0 = cyc_n;
`ifdef MEM_ARB_TIMEOUT_EN
    wait_done(30, at);
    chk("tmo_latency", 32'(at - i0), 32'(TMO + 1));
    chk("tmo_err", 32'(err), 32'd1);
    chk("tmo_rdata", 32'(rdata), 32'h0);
    req_valid = '0;
    drain();
`else
    repeat (1000) cyc();
    chk("stuck_cycles", 32'(cyc_n - i0), 32'd1000);
    chk("stuck_busy", 32'(busy), 32'd1);
    rst_n = 1'b0; req_valid = '0;
    cyc();
    rst_n = 1'b1;
    cyc();
`endif

    // randomized traffic with variable memory latency and stray pulses
    lat_rand = 1'b1; stray = 1'b1; rnd_req = 1'b1;
    repeat (400) cyc();
    rnd_req = 1'b0; stray = 1'b0; req_valid = '0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter sharing the single 4096×16 word memory port between up to `NUM_REQ` requesters (evaluator FSM, loader, display/debug reader). It sits between the requesters and the memory module: it serialises requests, drives the memory's one-cycle request strobe and address, waits for the memory's ready pulse, and returns the data word to the winning requester with a one-cycle done pulse.

## Interface
- `NUM_REQ`, 2: number of requesters, 2..4.
- `TIMEOUT_CYCLES`, 255: WAIT-state cycle limit; used only with the timeout feature; 1..255.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  NUM_REQ  per-requester request; held high with address stable until that requester's `done` bit.
- `req_addr`  in  12*NUM_REQ  flattened word addresses; requester i at bits [12i+11:12i].
- `done`  out  NUM_REQ  one-cycle pulse to the served requester; `rdata` and `err` valid that cycle.
- `rdata`  out  16  read data word.
- `err`  out  1  high with `done` when the access timed out.
- `busy`  out  1  high in every state except IDLE.
- `mem_req`  out  1  memory request strobe, exactly one cycle per access.
- `mem_addr`  out  12  memory word address.
- `mem_ready`  in  1  memory data-valid pulse.
- `mem_data`  in  16  memory read data, valid while `mem_ready` is high.

## Operation
- States: IDLE, ISSUE, WAIT, DONE. All outputs are registered.
- IDLE: if any `req_valid` bit is set, pick the winner. Latch its index and address, then go to ISSUE. Otherwise stay in IDLE.
- Winner selection: the first set bit scanning upward from `(last+1) mod NUM_REQ`, wrapping around. `last` is updated to the winner index on entry to ISSUE.
- ISSUE, one cycle: `mem_req`=1 and `mem_addr` = latched address. Go to WAIT.
- WAIT:
  - `mem_req`=0; `mem_addr` is held.
  - On the first cycle with `mem_ready`=1: capture `mem_data` and go to DONE.
  - `mem_ready` is ignored in every state except WAIT.
- DONE, one cycle: `done[idx]`=1 and `rdata` = captured word. Go to IDLE.
- A requester that keeps `req_valid` high after `done` is treated as a new request and re-arbitrated.
- `req_valid` bits that drop before being granted are never served.
- Reset values:
  - state = IDLE; `last` = NUM_REQ-1, so requester 0 has first priority.
  - `done`=0, `rdata`=0, `err`=0, `busy`=0, `mem_req`=0, `mem_addr`=0.
- Reset asserted mid-access aborts the access immediately. No `done` is issued for it. A late `mem_ready` after reset is ignored because the arbiter is in IDLE.

## Timing
- `req_valid` sampled high in IDLE at cycle t gives:
  - `mem_req` and `mem_addr` at cycle t+1 (ISSUE).
  - WAIT from cycle t+2.
  - `mem_ready` at cycle w ≥ t+2 gives `done`/`rdata` at cycle w+1 and IDLE at w+2.
- With a memory that answers one cycle after the request: `done` at t+3, next arbitration at t+4. Peak throughput is one access per 4 cycles.
- `rdata` holds its value until the next DONE. `done` and `err` are high only in DONE.
- Simultaneous requests: exactly one is granted per arbitration. Between grants, every continuously requesting input waits at most NUM_REQ-1 accesses.

## Configuration
- Macro: `MEM_ARB_TIMEOUT_EN`.
- Defined:
  - An 8-bit counter clears on entry to WAIT and increments every WAIT cycle without `mem_ready`.
  - When the counter reaches TIMEOUT_CYCLES, go to DONE with `err`=1 and `rdata`=16'h0000.
  - A `mem_ready` arriving on the same cycle as the limit wins: normal completion with `err`=0.
- Not defined: no counter; WAIT lasts until `mem_ready`; `err` is tied to 0.

## Test plan
- Reset/single read:
  - Stimulus: `rst_n` low, then release. Requester 0 asks for addr 0x001. Memory returns 0x002A one cycle after `mem_req`.
  - Required: all outputs 0 during reset. `mem_req` one cycle with `mem_addr`=0x001. `done`=2'b01 and `rdata`=0x002A three cycles after `req_valid` was sampled.
- Contention (NUM_REQ=2):
  - Stimulus: both requesters hold `req_valid` from reset release.
  - Required: grants alternate 0,1,0,1 across four accesses. Each `done` is a single-cycle pulse.
- Slow memory:
  - Stimulus: `mem_ready` arrives 10 cycles after `mem_req`. `mem_ready` is also pulsed in IDLE and ISSUE.
  - Required: `mem_req` is never reasserted. The stray pulses are ignored. `done` one cycle after the real `mem_ready`. `mem_addr` is stable throughout WAIT.
- Reset mid-WAIT:
  - Stimulus: `rst_n` low for 2 cycles during WAIT, then `mem_ready` after release.
  - Required: no `done`. `busy`=0. Next arbitration starts from requester 0.
- Timeout (`MEM_ARB_TIMEOUT_EN`, TIMEOUT_CYCLES=8):
  - Stimulus: memory never responds.
  - Required: `done` with `err`=1 and `rdata`=0x0000 after 8 WAIT cycles.
  - Rerun without the macro: arbiter stays in WAIT for 1000 cycles with `busy`=1.
